if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 89 ++++++++
 tb/tb_if_id_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register. It handles branch flush, hazard holds,
// memory-wait bubbles and a saturating bubble counter.
// Optional build macro IFID_DELAY_SLOT_EN: a branch redirects the PC but keeps the delay-slot fetch.
module if_id_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_PCWrite,
  input  logic        IF_IFIDWrite,
  input  logic        IF_branchTaken,
  input  logic [15:0] IF_branchTarget,
  output logic [15:0] IF_imAddr,
  input  logic [15:0] IF_imData,
  input  logic        IF_imReady,
  output logic [15:0] IF_instruction_IFID,
  output logic [15:0] IF_PCplus1_IFID,
  output logic        IF_valid_IFID,
  output logic [15:0] IF_bubbleCount
);

`ifdef IFID_DELAY_SLOT_EN
  localparam bit FLUSH_ON_BRANCH = 1'b0;
`else
  localparam bit FLUSH_ON_BRANCH = 1'b1;
`endif

  typedef enum logic [1:0] {BOOT, RUN, MEMWAIT} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] cnt_sat;

  assign pc_inc    = pc + 16'd1;
  assign cnt_sat   = (IF_bubbleCount == 16'hFFFF) ? IF_bubbleCount : IF_bubbleCount + 16'd1;
  assign IF_imAddr = pc;

  // A bubble keeps IF_PCplus1_IFID; only the instruction and valid change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= BOOT;
      pc                  <= RESET_PC;
      IF_instruction_IFID <= NOP_INSTR;
      IF_PCplus1_IFID     <= 16'h0000;
      IF_valid_IFID       <= 1'b0;
      IF_bubbleCount      <= 16'h0000;
    end else begin
      case (state)
        BOOT: begin
          IF_instruction_IFID <= NOP_INSTR;
          IF_valid_IFID       <= 1'b0;
          IF_bubbleCount      <= cnt_sat;
          state               <= RUN;
        end
        default: begin
          if (IF_branchTaken)
            pc <= IF_branchTarget;
          else if (!IF_PCWrite && IF_imReady)
            pc <= pc_inc;

          if (IF_branchTaken && FLUSH_ON_BRANCH) begin
            IF_instruction_IFID <= NOP_INSTR;
            IF_valid_IFID       <= 1'b0;
            IF_bubbleCount      <= cnt_sat;
          end else if (!IF_IFIDWrite) begin
            if (IF_imReady) begin
              IF_instruction_IFID <= IF_imData;
              IF_PCplus1_IFID     <= pc_inc;
              IF_valid_IFID       <= 1'b1;
            end else begin
              IF_instruction_IFID <= NOP_INSTR;
              IF_valid_IFID       <= 1'b0;
              IF_bubbleCount      <= cnt_sat;
            end
          end

          // A full hold freezes the FSM; otherwise memory readiness picks the state.
          if (IF_branchTaken)
            state <= RUN;
          else if (!(IF_PCWrite && IF_IFIDWrite))
            state <= IF_imReady ? RUN : MEMWAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver queues expected post-edge state and
// a negedge monitor pops and compares it.
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        pcw, ifw, br, rdy;
  logic [15:0] tgt, dat;
  logic [15:0] im_addr, instr, pcp1, cnt;
  logic        vld;

  typedef struct {
    string       tag;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pcp1;
    logic        vld;
    logic [15:0] cnt;
    bit          chk_pcp1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [15:0] NOP = 16'h0800;

  if_id_stage dut (
    .clk(clk), .rst(rst),
    .IF_PCWrite(pcw), .IF_IFIDWrite(ifw),
    .IF_branchTaken(br), .IF_branchTarget(tgt),
    .IF_imAddr(im_addr), .IF_imData(dat), .IF_imReady(rdy),
    .IF_instruction_IFID(instr), .IF_PCplus1_IFID(pcp1),
    .IF_valid_IFID(vld), .IF_bubbleCount(cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (im_addr !== e.addr || instr !== e.instr || vld !== e.vld || cnt !== e.cnt ||
          (e.chk_pcp1 && pcp1 !== e.pcp1)) begin
        errors++;
        $display("FAIL %s: got addr=%h instr=%h pcp1=%h vld=%b cnt=%h, exp addr=%h instr=%h pcp1=%h vld=%b cnt=%h",
                 e.tag, im_addr, instr, pcp1, vld, cnt, e.addr, e.instr, e.pcp1, e.vld, e.cnt);
      end
    end
  end

  task automatic push(input string tag, input logic [15:0] a, i, p, input logic v,
                      input logic [15:0] c, input bit cp);
    exp_t e;
    e.tag = tag; e.addr = a; e.instr = i; e.pcp1 = p; e.vld = v; e.cnt = c; e.chk_pcp1 = cp;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs; the expectation describes state after the next rising edge.
  task automatic step(input logic r, w_pc, w_ifid, b, input logic [15:0] t,
                      input logic rd, input logic [15:0] d, input bit chk, input string tag,
                      input logic [15:0] a, i, p, input logic v, input logic [15:0] c,
                      input bit cp = 1'b1);
    @(negedge clk);
    #1;
    rst = r; pcw = w_pc; ifw = w_ifid; br = b; tgt = t; rdy = rd; dat = d;
    if (chk) push(tag, a, i, p, v, c, cp);
  endtask

  initial begin
    rst = 1'b0; pcw = 0; ifw = 0; br = 0; tgt = 0; rdy = 0; dat = 0;
    //   rst pcw ifw br tgt      rdy dat      chk tag            addr     instr    pcp1     v  cnt
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, "reset",        16'h0000, NOP,     16'h0000, 0, 16'd0);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h1111, 1, "boot_bubble",  16'h0000, NOP,     16'h0000, 0, 16'd1);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h1111, 1, "fetch_1111",   16'h0001, 16'h1111, 16'h0001, 1, 16'd1);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h2222, 1, "fetch_2222",   16'h0002, 16'h2222, 16'h0002, 1, 16'd1);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h3333, 1, "fetch_3333",   16'h0003, 16'h3333, 16'h0003, 1, 16'd1);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h4444, 1, "fetch_4444",   16'h0004, 16'h4444, 16'h0004, 1, 16'd1);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h5555, 1, "fetch_5555",   16'h0005, 16'h5555, 16'h0005, 1, 16'd1);
    for (int k = 0; k < 3; k++)
      step(1, 1, 1, 0, 16'h0000, 1, 16'hAAAA, 1, "full_hold",  16'h0005, 16'h5555, 16'h0005, 1, 16'd1);
    step(1, 1, 0, 0, 16'h0000, 1, 16'h6666, 1, "pc_hold_only", 16'h0005, 16'h6666, 16'h0006, 1, 16'd1);
    step(1, 0, 1, 0, 16'h0000, 1, 16'h7777, 1, "ifid_hold_only",16'h0006, 16'h6666, 16'h0006, 1, 16'd1);
    step(1, 0, 0, 1, 16'h0010, 1, 16'hBEEF, 1, "branch_0010",  16'h0010, NOP,     16'h0000, 0, 16'd2, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 16'hDEAD, 1, "memwait_1",    16'h0010, NOP,     16'h0000, 0, 16'd3, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 16'hDEAD, 1, "memwait_2",    16'h0010, NOP,     16'h0000, 0, 16'd4, 0);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h1234, 1, "after_wait",   16'h0011, 16'h1234, 16'h0011, 1, 16'd4);
    step(1, 0, 1, 1, 16'h0040, 1, 16'h9999, 1, "branch_flush", 16'h0040, NOP,     16'h0000, 0, 16'd5, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, "wait_at_40",   16'h0040, NOP,     16'h0000, 0, 16'd6, 0);
    step(1, 0, 0, 1, 16'h0100, 0, 16'h0000, 1, "branch_in_wait",16'h0100, NOP,    16'h0000, 0, 16'd7, 0);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h5A5A, 1, "fetch_new_pc", 16'h0101, 16'h5A5A, 16'h0101, 1, 16'd7);
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, "wait_101",     16'h0101, NOP,     16'h0000, 0, 16'd8, 0);
    step(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, "hold_in_wait", 16'h0101, NOP,     16'h0000, 0, 16'd8, 0);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h7E7E, 1, "fetch_7e7e",   16'h0102, 16'h7E7E, 16'h0102, 1, 16'd8);
    step(1, 0, 0, 1, 16'hFFFF, 1, 16'h0000, 1, "branch_ffff",  16'hFFFF, NOP,     16'h0000, 0, 16'd9, 0);
    step(1, 0, 0, 0, 16'h0000, 1, 16'hCAFE, 1, "pc_wrap",      16'h0000, 16'hCAFE, 16'h0000, 1, 16'd9);
    // Stall memory until the bubble counter sits at 0xFFFD, then watch it saturate.
    for (int k = 0; k < 65524; k++)
      step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, "", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, "cnt_fffe",     16'h0000, NOP,     16'h0000, 0, 16'hFFFE, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, "cnt_ffff",     16'h0000, NOP,     16'h0000, 0, 16'hFFFF, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, "cnt_sat",      16'h0000, NOP,     16'h0000, 0, 16'hFFFF, 0);
    // Async reset mid-MEMWAIT: drop rst just after a rising edge and expect reset state by the falling edge.
    step(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, "async_reset",  RESET_VAL_PC(), NOP, 16'h0000, 0, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 0, 0, 0, 16'h0000, 1, 16'h4321, 1, "reboot_bubble",16'h0000, NOP,     16'h0000, 0, 16'd1);
    step(1, 0, 0, 0, 16'h0000, 1, 16'h4321, 1, "reboot_fetch", 16'h0001, 16'h4321, 16'h0001, 1, 16'd1);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [15:0] RESET_VAL_PC();
    return 16'h0000;
  endfunction
endmodule
